mem_bus_arbiter: RTL

- Two-master, one-slave arbiter for the 32-bit valid/ready core memory bus.
- Shares the top-level address decoder/mux between the CPU (master 0) and a secondary bus master (master 1), e.g. a DMA/loader.
- Round-robin grant; the granted transaction is locked until the slave responds.
- Response is registered back to the owning master.
- Optional watchdog terminates hung slave accesses.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the core memory bus arbiter.
// Constants only; no logic, no latency, no flow control.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // All-zero word decodes as an illegal instruction, so a timed-out fetch traps.
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA_DEF = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: combinational select, registered last winner.
// Zero-cycle select; last_grant advances only when the caller commits a grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       sel,
  output logic       any
);

  logic last_grant;

  always_comb begin
    any = |req;
    sel = 1'b0;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant;
      default: sel = 1'b0;
    endcase
  end

  // Resets to 1 so master 0 wins the first contended arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= sel;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master/one-slave round-robin arbiter for the valid/ready core memory bus.
// Request->s_valid 1 cycle, s_ready->m_ready 1 cycle; slave stalls hold the bus locked.
// MEM_BUS_ARBITER_TIMEOUT_EN adds a watchdog that force-completes hung accesses.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned         TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0]   TIMEOUT_RDATA  = TIMEOUT_RDATA_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,

  output logic              grant_id,
  output logic              timeout_err
);

  state_t              state;
  state_t              state_nxt;
  logic                sel;
  logic                req_any;
  logic                grant;
  logic                tmo_hit;
  logic                tmo_fire;
  logic                grant_id_q;
  logic                req_instr;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [STRB_W-1:0]   req_wstrb;
  logic [DATA_W-1:0]   rsp;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({m1_valid, m0_valid}),
    .update (grant),
    .sel    (sel),
    .any    (req_any)
  );

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog;
  logic        tmo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog  <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_fire;
      if (grant) begin
        wdog <= '0;
      end else if (state == BUSY) begin
        wdog <= wdog + 16'd1;
      end
    end
  end

  assign tmo_hit     = (wdog == WDOG_LAST);
  assign timeout_err = tmo_q;
`else
  // Without the watchdog the cycle limit has no meaning.
  logic [15:0] unused_tmo_cycles;
  assign unused_tmo_cycles = 16'(TIMEOUT_CYCLES);

  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          grant     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A real response in the last watchdog cycle wins over the timeout.
        if (s_ready) begin
          state_nxt = RESP;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id_q <= 1'b0;
      req_instr  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_wstrb  <= '0;
      rsp        <= '0;
    end else begin
      if (grant) begin
        grant_id_q <= sel;
        req_instr  <= sel ? m1_instr : m0_instr;
        req_addr   <= sel ? m1_addr  : m0_addr;
        req_wdata  <= sel ? m1_wdata : m0_wdata;
        req_wstrb  <= sel ? m1_wstrb : m0_wstrb;
      end
      if (state == BUSY && s_ready) begin
        rsp <= s_rdata;
      end else if (tmo_fire) begin
        rsp <= TIMEOUT_RDATA;
      end
    end
  end

  assign s_valid  = (state == BUSY);
  assign s_instr  = s_valid ? req_instr : 1'b0;
  assign s_addr   = s_valid ? req_addr  : '0;
  assign s_wdata  = s_valid ? req_wdata : '0;
  assign s_wstrb  = s_valid ? req_wstrb : '0;

  assign grant_id = grant_id_q;
  assign m0_ready = (state == RESP) && !grant_id_q;
  assign m1_ready = (state == RESP) &&  grant_id_q;
  assign m0_rdata = m0_ready ? rsp : '0;
  assign m1_rdata = m1_ready ? rsp : '0;

endmodule
